unified_mem_arbiter: RTL

Arbitrates the single-ported unified instruction/data memory between two requesters: the fetch stage (IF) and the data stage (MEM, loads/stores).
- Grants one access at a time, round-robin.
- Sequences the memory port through a fixed-latency access.
- Returns read data with a one-cycle ack pulse.
- Drives per-requester stall lines into the pipeline's hazard logic.
- Sits between the pipeline registers and the Mem instance.

---
 rtl/unified_mem_arbiter_if.sv | 48 ++++
 rtl/unified_mem_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle between the pipeline stages, the arbiter and the unified memory.
// The arbiter takes the slave view; the pipeline/memory side takes the master view.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_kill;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              if_stall;
    // data requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_func3;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              d_stall;
    // memory port
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [2:0]        mem_func3;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, if_kill,
        input  d_req, d_we, d_addr, d_wdata, d_func3,
        input  mem_rdata,
        output if_ack, if_rdata, if_stall,
        output d_ack, d_rdata, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_func3
    );

    modport master (
        output if_req, if_addr, if_kill,
        output d_req, d_we, d_addr, d_wdata, d_func3,
        output mem_rdata,
        input  if_ack, if_rdata, if_stall,
        input  d_ack, d_rdata, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_func3
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter for the single-ported unified instruction/data memory.
// One access at a time: IDLE (arbitrate) -> ACCESS (LAT cycles) -> DONE (ack) -> IDLE.
//
//   state  | meaning
//   IDLE   | no access in flight; arbitrate between fetch and data
//   ACCESS | memory port enabled, counting down the fixed latency
//   DONE   | one-cycle ack to the winner; no arbitration
module unified_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    unified_mem_arbiter_if.slave   bus,
    output logic                   busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic {P_DATA, P_FETCH} prio_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);
    localparam logic [2:0] FETCH_FUNC3 = 3'b010;

    state_t            state_q, state_d;
    prio_t             prio_q, prio_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              sel_data_q, sel_data_d;   // winner of the current access is the data stage
    logic              kill_q, kill_d;           // in-flight fetch was flushed
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        mem_func3_q, mem_func3_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              grant_data;
    logic              grant_fetch;

    // Next-state, arbitration and datapath capture.
    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        sel_data_d  = sel_data_q;
        kill_d      = kill_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_func3_d = mem_func3_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;

        grant_data  = bus.d_req & (~bus.if_req | (prio_q == P_DATA));
        grant_fetch = bus.if_req & ~grant_data;

        case (state_q)
            S_IDLE: begin
                if (grant_data || grant_fetch) begin
                    state_d    = S_ACCESS;
                    mem_en_d   = 1'b1;
                    cnt_d      = CNT_INIT;
                    kill_d     = 1'b0;
                    sel_data_d = grant_data;
                    if (grant_data) begin
                        mem_we_d    = bus.d_we;
                        mem_addr_d  = bus.d_addr;
                        mem_wdata_d = bus.d_wdata;
                        mem_func3_d = bus.d_func3;
                        prio_d      = P_FETCH;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.if_addr;
                        mem_wdata_d = '0;
                        mem_func3_d = FETCH_FUNC3;
                        prio_d      = P_DATA;
                    end
                end
            end
            S_ACCESS: begin
                if (bus.if_kill && !sel_data_q) begin
                    kill_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d  = S_DONE;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if (sel_data_q) begin
                        d_ack_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end else if (!(kill_q || bus.if_kill)) begin
                        // A flushed fetch still completes on the memory side, but the
                        // stale instruction is dropped so if_rdata keeps its last value.
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            prio_q      <= P_DATA;
            cnt_q       <= '0;
            sel_data_q  <= 1'b0;
            kill_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_func3_q <= 3'b000;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            sel_data_q  <= sel_data_d;
            kill_q      <= kill_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_func3_q <= mem_func3_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_func3 = mem_func3_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    // Stalls are combinational so the stage advances in the ack cycle itself.
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.d_stall   = bus.d_req & ~d_ack_q;
    assign busy          = (state_q != S_IDLE);

endmodule
